// File: rtl/branch_predictor_bht_if.sv
// Fetch/resolve bus between the pipeline and the branch predictor.
// The master side drives the fetch and resolve inputs; the predictor is the slave.
interface branch_predictor_bht_if #(
   parameter int unsigned CNT_WIDTH = 16
);
   logic [31:0]          fetchPC;
   logic [31:0]          fetchInstruction;
   logic                 predTaken;
   logic [31:0]          predTarget;
   logic                 resValid;
   logic [31:0]          resPC;
   logic [31:0]          resInstruction;
   logic                 resBranch;
   logic                 resPredTaken;
   logic                 redirect;
   logic [31:0]          redirectPC;
   logic [CNT_WIDTH-1:0] mispredictCount;

   modport master (
      output fetchPC, fetchInstruction, resValid, resPC, resInstruction, resBranch, resPredTaken,
      input  predTaken, predTarget, redirect, redirectPC, mispredictCount
   );

   modport slave (
      input  fetchPC, fetchInstruction, resValid, resPC, resInstruction, resBranch, resPredTaken,
      output predTaken, predTarget, redirect, redirectPC, mispredictCount
   );
endinterface

// File: rtl/branch_predictor_bht.sv
// Bimodal branch predictor: 2-bit counter table looked up at fetch, trained from EX,
// with a registered one-cycle redirect on mispredict and a saturating mispredict count.
module branch_predictor_bht #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input logic                   clk,
   input logic                   rst,
   branch_predictor_bht_if.slave bp
);
   localparam int unsigned Entries  = 2 ** INDEX_BITS;
   localparam logic [6:0]  OpBranch = 7'b1100011;

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   logic [1:0]           table_q [Entries];
   logic [1:0]           table_d [Entries];
   logic                 redirect_q, redirect_d;
   logic [31:0]          redirect_pc_q, redirect_pc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [INDEX_BITS-1:0] fetch_idx, res_idx;
   logic                  fetch_is_br, res_upd, mispredict;
   logic [1:0]            res_entry;

   assign fetch_idx   = bp.fetchPC[INDEX_BITS+1:2];
   assign res_idx     = bp.resPC[INDEX_BITS+1:2];
   assign fetch_is_br = (bp.fetchInstruction[6:0] == OpBranch);
   assign res_upd     = bp.resValid & (bp.resInstruction[6:0] == OpBranch);
   assign mispredict  = res_upd & (bp.resBranch != bp.resPredTaken);
   assign res_entry   = table_q[res_idx];

   // Lookup sees the registered table only, so a same-cycle update is not bypassed.
   assign bp.predTaken       = fetch_is_br & table_q[fetch_idx][1];
   assign bp.predTarget      = bp.fetchPC + imm_b(bp.fetchInstruction);
   assign bp.redirect        = redirect_q;
   assign bp.redirectPC      = redirect_pc_q;
   assign bp.mispredictCount = cnt_q;

   always_comb begin
      table_d = table_q;
      if (res_upd) begin
         if (bp.resBranch && res_entry != 2'b11) begin
            table_d[res_idx] = res_entry + 2'b01;
         end else if (!bp.resBranch && res_entry != 2'b00) begin
            table_d[res_idx] = res_entry - 2'b01;
         end
      end
   end

   always_comb begin
      redirect_d    = mispredict;
      redirect_pc_d = redirect_pc_q;
      cnt_d         = cnt_q;
      if (mispredict) begin
         redirect_pc_d = bp.resBranch ? bp.resPC + imm_b(bp.resInstruction) : bp.resPC + 32'd4;
         if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Entries; i++) begin
            table_q[i] <= 2'b01;
         end
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'h0;
         cnt_q         <= '0;
      end else begin
         table_q       <= table_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         cnt_q         <= cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: lookup, training, redirect, counter saturation, reset.
module tb_branch_predictor_bht;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   branch_predictor_bht_if #(.CNT_WIDTH(16)) bus ();
   branch_predictor_bht_if #(.CNT_WIDTH(2))  bus2 ();

   branch_predictor_bht #(.INDEX_BITS(6), .CNT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bus)
   );

   branch_predictor_bht #(.INDEX_BITS(6), .CNT_WIDTH(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bp  (bus2)
   );

   function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
      logic [12:0] v;
      v = imm[12:0];
      return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
   endfunction

   localparam logic [31:0] Addi = 32'h00100093;
   logic [31:0] beq16, bnem8;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
      bus.fetchPC          = pc;
      bus.fetchInstruction = instr;
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [31:0] instr, input logic br,
                          input logic pt);
      bus.resValid       = 1'b1;
      bus.resPC          = pc;
      bus.resInstruction = instr;
      bus.resBranch      = br;
      bus.resPredTaken   = pt;
      step();
      bus.resValid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tests++;
      if (bus.redirect !== 1'b0) begin
         fails++; $display("FAIL reset_redirect got %0b want 0", bus.redirect);
      end
      tests++;
      if (bus.redirectPC !== 32'h0) begin
         fails++; $display("FAIL reset_redirect_pc got %h want 00000000", bus.redirectPC);
      end
      tests++;
      if (bus.mispredictCount !== 16'd0) begin
         fails++; $display("FAIL reset_count got %0d want 0", bus.mispredictCount);
      end
      fetch(32'h100, beq16);
      tests++;
      if (bus.predTaken !== 1'b0) begin
         fails++; $display("FAIL lookup_initial got %0b want 0", bus.predTaken);
      end
      tests++;
      if (bus.predTarget !== 32'h110) begin
         fails++; $display("FAIL lookup_target got %h want 00000110", bus.predTarget);
      end
   endtask

   task automatic test_mispredict();
      resolve(32'h100, beq16, 1'b1, 1'b0);
      tests++;
      if (bus.redirect !== 1'b1) begin
         fails++; $display("FAIL misp_redirect got %0b want 1", bus.redirect);
      end
      tests++;
      if (bus.redirectPC !== 32'h110) begin
         fails++; $display("FAIL misp_redirect_pc got %h want 00000110", bus.redirectPC);
      end
      tests++;
      if (bus.mispredictCount !== 16'd1) begin
         fails++; $display("FAIL misp_count got %0d want 1", bus.mispredictCount);
      end
      tests++;
      if (bus.predTaken !== 1'b1) begin
         fails++; $display("FAIL misp_refetch got %0b want 1", bus.predTaken);
      end
      step();
      tests++;
      if (bus.redirect !== 1'b0 || bus.redirectPC !== 32'h110) begin
         fails++;
         $display("FAIL misp_pulse_end got %0b/%h want 0/00000110", bus.redirect, bus.redirectPC);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) resolve(32'h100, beq16, 1'b1, 1'b1);
      tests++;
      if (bus.redirect !== 1'b0 || bus.mispredictCount !== 16'd1) begin
         fails++;
         $display("FAIL sat_correct got %0b/%0d want 0/1", bus.redirect, bus.mispredictCount);
      end
      resolve(32'h100, beq16, 1'b0, 1'b1);
      tests++;
      if (bus.redirect !== 1'b1 || bus.redirectPC !== 32'h104) begin
         fails++;
         $display("FAIL sat_nt_redirect got %0b/%h want 1/00000104", bus.redirect, bus.redirectPC);
      end
      tests++;
      if (bus.mispredictCount !== 16'd2) begin
         fails++; $display("FAIL sat_nt_count got %0d want 2", bus.mispredictCount);
      end
      // 11 held at saturation, so one not-taken leaves 10 (still predicts taken)
      tests++;
      if (bus.predTaken !== 1'b1) begin
         fails++; $display("FAIL sat_entry_10 got %0b want 1", bus.predTaken);
      end
      resolve(32'h100, beq16, 1'b0, 1'b0);
      tests++;
      if (bus.predTaken !== 1'b0 || bus.redirect !== 1'b0) begin
         fails++;
         $display("FAIL sat_entry_01 got %0b/%0b want 0/0", bus.predTaken, bus.redirect);
      end
   endtask

   task automatic test_backward();
      fetch(32'h4, bnem8);
      tests++;
      if (bus.predTarget !== 32'hFFFFFFFC || bus.predTaken !== 1'b0) begin
         fails++;
         $display("FAIL bwd_lookup got %h/%0b want fffffffc/0", bus.predTarget, bus.predTaken);
      end
      resolve(32'h4, bnem8, 1'b1, 1'b0);
      tests++;
      if (bus.redirect !== 1'b1 || bus.redirectPC !== 32'hFFFFFFFC) begin
         fails++;
         $display("FAIL bwd_redirect got %0b/%h want 1/fffffffc", bus.redirect, bus.redirectPC);
      end
      tests++;
      if (bus.mispredictCount !== 16'd3 || bus.predTaken !== 1'b1) begin
         fails++;
         $display("FAIL bwd_count_pred got %0d/%0b want 3/1", bus.mispredictCount, bus.predTaken);
      end
   endtask

   task automatic test_no_update();
      resolve(32'h108, Addi, 1'b1, 1'b0);
      tests++;
      if (bus.redirect !== 1'b0 || bus.mispredictCount !== 16'd3) begin
         fails++;
         $display("FAIL noupd_addi got %0b/%0d want 0/3", bus.redirect, bus.mispredictCount);
      end
      bus.resValid       = 1'b0;
      bus.resPC          = 32'h108;
      bus.resInstruction = beq16;
      bus.resBranch      = 1'b1;
      bus.resPredTaken   = 1'b0;
      step();
      tests++;
      if (bus.redirect !== 1'b0 || bus.mispredictCount !== 16'd3) begin
         fails++;
         $display("FAIL noupd_invalid got %0b/%0d want 0/3", bus.redirect, bus.mispredictCount);
      end
      fetch(32'h108, beq16);
      tests++;
      if (bus.predTaken !== 1'b0) begin
         fails++; $display("FAIL noupd_entry got %0b want 0", bus.predTaken);
      end
      // Entry at 0x4 predicts taken, but a non-branch must not.
      fetch(32'h4, Addi);
      tests++;
      if (bus.predTaken !== 1'b0 || bus.predTarget !== 32'h804) begin
         fails++;
         $display("FAIL nonbranch got %0b/%h want 0/00000804", bus.predTaken, bus.predTarget);
      end
   endtask

   task automatic test_back_to_back();
      bus.resValid       = 1'b1;
      bus.resPC          = 32'h108;
      bus.resInstruction = beq16;
      bus.resBranch      = 1'b1;
      bus.resPredTaken   = 1'b0;
      step();
      tests++;
      if (bus.redirect !== 1'b1 || bus.redirectPC !== 32'h118) begin
         fails++;
         $display("FAIL b2b_first got %0b/%h want 1/00000118", bus.redirect, bus.redirectPC);
      end
      bus.resPC        = 32'h10C;
      bus.resBranch    = 1'b0;
      bus.resPredTaken = 1'b1;
      step();
      bus.resValid = 1'b0;
      tests++;
      if (bus.redirect !== 1'b1 || bus.redirectPC !== 32'h110) begin
         fails++;
         $display("FAIL b2b_second got %0b/%h want 1/00000110", bus.redirect, bus.redirectPC);
      end
      tests++;
      if (bus.mispredictCount !== 16'd5) begin
         fails++; $display("FAIL b2b_count got %0d want 5", bus.mispredictCount);
      end
      step();
      tests++;
      if (bus.redirect !== 1'b0) begin
         fails++; $display("FAIL b2b_end got %0b want 0", bus.redirect);
      end
   endtask

   task automatic test_same_cycle();
      fetch(32'h110, beq16);
      bus.resValid       = 1'b1;
      bus.resPC          = 32'h110;
      bus.resInstruction = beq16;
      bus.resBranch      = 1'b1;
      bus.resPredTaken   = 1'b1;
      #1;
      tests++;
      if (bus.predTaken !== 1'b0) begin
         fails++; $display("FAIL same_pre got %0b want 0", bus.predTaken);
      end
      step();
      bus.resValid = 1'b0;
      #1;
      tests++;
      if (bus.predTaken !== 1'b1 || bus.redirect !== 1'b0) begin
         fails++;
         $display("FAIL same_post got %0b/%0b want 1/0", bus.predTaken, bus.redirect);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      resolve(32'h100, beq16, 1'b1, 1'b0);
      tests++;
      if (bus.redirect !== 1'b1 || bus.mispredictCount !== 16'd6) begin
         fails++;
         $display("FAIL rmid_pre got %0b/%0d want 1/6", bus.redirect, bus.mispredictCount);
      end
      rst = 1'b1;
      step();
      tests++;
      if (bus.redirect !== 1'b0 || bus.redirectPC !== 32'h0 || bus.mispredictCount !== 16'd0) begin
         fails++;
         $display("FAIL rmid_clear got %0b/%h/%0d want 0/00000000/0", bus.redirect,
                  bus.redirectPC, bus.mispredictCount);
      end
      // Mispredict resolved while reset is held: reset wins.
      resolve(32'h4, bnem8, 1'b1, 1'b0);
      rst = 1'b0;
      tests++;
      if (bus.redirect !== 1'b0 || bus.mispredictCount !== 16'd0) begin
         fails++;
         $display("FAIL rmid_override got %0b/%0d want 0/0", bus.redirect, bus.mispredictCount);
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (dut.table_q[i] !== 2'b01) bad++;
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL rmid_table got %0d entries not 01 want 0", bad);
      end
      fetch(32'h4, bnem8);
      tests++;
      if (bus.predTaken !== 1'b0) begin
         fails++; $display("FAIL rmid_lookup got %0b want 0", bus.predTaken);
      end
   endtask

   task automatic test_count_saturate();
      logic [1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
         bus2.resValid       = 1'b1;
         bus2.resPC          = 32'h20 + 32'(i * 4);
         bus2.resInstruction = beq16;
         bus2.resBranch      = 1'b1;
         bus2.resPredTaken   = 1'b0;
         step();
         tests++;
         if (bus2.mispredictCount !== exp_cnt[i]) begin
            fails++;
            $display("FAIL cnt_sat[%0d] got %0d want %0d", i, bus2.mispredictCount, exp_cnt[i]);
         end
      end
      bus2.resValid = 1'b0;
   endtask

   initial begin
      beq16 = enc_b(16, 3'b000);
      bnem8 = enc_b(-8, 3'b001);
      bus.fetchPC = 32'h0;   bus.fetchInstruction = 32'h0;  bus.resValid = 1'b0;
      bus.resPC = 32'h0;     bus.resInstruction = 32'h0;    bus.resBranch = 1'b0;
      bus.resPredTaken = 1'b0;
      bus2.fetchPC = 32'h0;  bus2.fetchInstruction = 32'h0; bus2.resValid = 1'b0;
      bus2.resPC = 32'h0;    bus2.resInstruction = 32'h0;   bus2.resBranch = 1'b0;
      bus2.resPredTaken = 1'b0;
      test_reset();
      test_mispredict();
      test_saturation();
      test_backward();
      test_no_update();
      test_back_to_back();
      test_same_cycle();
      test_reset_mid();
      test_count_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
